// File: rtl/credit_tx_stage.sv
// credit_tx_stage: one register level of the forward link plus credit-return path.
// Valid and credit bits reset; data does not, so it stays prunable.
module credit_tx_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_credit,
   (* keep = "true" *) output logic                  out_valid,
   (* keep = "true" *) output logic [DATA_WIDTH-1:0] out_data,
   (* keep = "true" *) output logic                  out_credit
);
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_credit <= 1'b0;
      end else begin
         out_valid  <= in_valid;
         out_credit <= in_credit;
      end
   end
   always_ff @(posedge clk) out_data <= in_data;
endmodule

// File: rtl/relay_credit_tx.sv
// relay_credit_tx: credit-based sender relaying an FWFT FIFO over a LEVEL-deep registered link.
// Credit round trip is 2*LEVEL+1 cycles; the counter saturates and flags overflow on excess credit.
module relay_credit_tx #(
   parameter int DATA_WIDTH = 32,
   parameter int LEVEL      = 2,
   parameter int CREDITS    = 6
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         if_empty_n,
   input  logic                         if_read_ce,
   output logic                         if_read,
   input  logic [DATA_WIDTH-1:0]        if_dout,
   output logic                         link_valid,
   output logic [DATA_WIDTH-1:0]        link_data,
   input  logic                         link_credit,
   output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
   output logic                         credit_overflow
);
   localparam int CNT_WIDTH = $clog2(CREDITS+1);
   localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CREDITS);
   logic                  v [0:LEVEL];
   logic [DATA_WIDTH-1:0] d [0:LEVEL];
   logic                  c [0:LEVEL];
   logic                  credit_ret;
   logic                  excess;
   logic [CNT_WIDTH-1:0]  cnt_next;
   assign v[0] = if_read;
   assign d[0] = if_dout;
   assign c[0] = link_credit;
   for (genvar i = 0; i < LEVEL; i++) begin : g_stage
      credit_tx_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
         .clk        (clk),
         .reset      (reset),
         .in_valid   (v[i]),
         .in_data    (d[i]),
         .in_credit  (c[i]),
         .out_valid  (v[i+1]),
         .out_data   (d[i+1]),
         .out_credit (c[i+1])
      );
   end
   assign link_valid = v[LEVEL];
   assign link_data  = d[LEVEL];
   assign credit_ret = c[LEVEL];
   // reset gating keeps the pop strobe quiet while reset is held
   always_comb begin
      if_read  = if_empty_n & if_read_ce & (credit_cnt != '0) & ~reset;
      excess   = credit_ret & ~if_read & (credit_cnt == FULL);
      cnt_next = excess ? FULL : credit_cnt - CNT_WIDTH'(if_read) + CNT_WIDTH'(credit_ret);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         credit_cnt      <= FULL;
         credit_overflow <= 1'b0;
      end else begin
         credit_cnt      <= cnt_next;
         credit_overflow <= credit_overflow | excess;
      end
   end
endmodule

// File: tb/tb_relay_credit_tx.sv
// tb_relay_credit_tx: directed self-checking bench; dut_a (CREDITS=4) covers fill, equal-cycle
// send/return, overflow, clock-enable gating and mid-stream reset; dut_b (CREDITS=6) covers loopback throughput.
module tb_relay_credit_tx;
   logic        clk = 1'b0;
   logic        ra, a_empty_n, a_ce, a_read, a_valid, a_credit, a_ovf;
   logic [31:0] a_dout, a_data;
   logic [2:0]  a_cnt;
   logic        rb, b_empty_n, b_ce, b_read, b_valid, b_ovf;
   logic [31:0] b_dout, b_data;
   logic [2:0]  b_cnt;
   int          n_chk = 0;
   int          n_fail = 0;
   always #5 clk = ~clk;
   relay_credit_tx #(.DATA_WIDTH(32), .LEVEL(2), .CREDITS(4)) dut_a (
      .clk(clk), .reset(ra), .if_empty_n(a_empty_n), .if_read_ce(a_ce), .if_read(a_read),
      .if_dout(a_dout), .link_valid(a_valid), .link_data(a_data), .link_credit(a_credit),
      .credit_cnt(a_cnt), .credit_overflow(a_ovf)
   );
   relay_credit_tx #(.DATA_WIDTH(32), .LEVEL(2), .CREDITS(6)) dut_b (
      .clk(clk), .reset(rb), .if_empty_n(b_empty_n), .if_read_ce(b_ce), .if_read(b_read),
      .if_dout(b_dout), .link_valid(b_valid), .link_data(b_data), .link_credit(b_valid),
      .credit_cnt(b_cnt), .credit_overflow(b_ovf)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // advance one cycle, drive dut_a, then let combinational logic settle before checks
   task automatic drv_a(input logic r, input logic e, input logic ce, input logic cr, input logic [31:0] dt);
      @(posedge clk);
      #1;
      ra = r; a_empty_n = e; a_ce = ce; a_credit = cr; a_dout = dt;
      #1;
   endtask
   initial begin
      ra = 1'b1; a_empty_n = 1'b1; a_ce = 1'b1; a_credit = 1'b0; a_dout = '0;
      rb = 1'b1; b_empty_n = 1'b1; b_ce = 1'b1; b_dout = '0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("rst_a_cnt", a_cnt, 4);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_a_ovf", a_ovf, 0);
      chk("rst_a_read", a_read, 0);
      chk("rst_b_cnt", b_cnt, 6);
      chk("rst_b_read", b_read, 0);
      // fill: 4 sends with no credit return, then stall at zero credits
      for (int k = 0; k < 10; k++) begin
         drv_a(1'b0, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(k));
         chk($sformatf("fill_read_%0d", k), a_read, (k <= 3) ? 1 : 0);
         chk($sformatf("fill_cnt_%0d", k), a_cnt, (k <= 4) ? 4 - k : 0);
         chk($sformatf("fill_valid_%0d", k), a_valid, (k >= 2 && k <= 5) ? 1 : 0);
         if (k >= 2 && k <= 5) chk($sformatf("fill_data_%0d", k), a_data, 32'h100 + 32'(k - 2));
      end
      // two credits: first lifts cnt to 1, second returns in the same cycle as a send
      drv_a(0, 0, 1, 1, 0);  chk("eq_t0_cnt", a_cnt, 0); chk("eq_t0_read", a_read, 0);
      drv_a(0, 0, 1, 1, 0);  chk("eq_t1_cnt", a_cnt, 0);
      drv_a(0, 0, 1, 0, 0);  chk("eq_t2_cnt", a_cnt, 0);
      drv_a(0, 1, 1, 0, 32'h200); chk("eq_t3_cnt", a_cnt, 1); chk("eq_t3_read", a_read, 1);
      drv_a(0, 1, 1, 0, 32'h201); chk("eq_t4_cnt", a_cnt, 1); chk("eq_t4_read", a_read, 1);
      drv_a(0, 0, 1, 0, 0);  chk("eq_t5_cnt", a_cnt, 0); chk("eq_t5_read", a_read, 0);
      chk("eq_t5_valid", a_valid, 1); chk("eq_t5_data", a_data, 32'h200);
      drv_a(0, 0, 1, 0, 0);  chk("eq_t6_valid", a_valid, 1); chk("eq_t6_data", a_data, 32'h201);
      drv_a(0, 0, 1, 0, 0);  chk("eq_t7_valid", a_valid, 0);
      for (int k = 0; k < 4; k++) drv_a(0, 0, 1, 1, 0);
      for (int k = 0; k < 3; k++) drv_a(0, 0, 1, 0, 0);
      chk("refill_cnt", a_cnt, 4);
      chk("refill_ovf", a_ovf, 0);
      // one excess credit while full
      drv_a(0, 0, 1, 1, 0);  chk("ovf_s0", a_ovf, 0);
      drv_a(0, 0, 1, 0, 0);  chk("ovf_s1", a_ovf, 0);
      drv_a(0, 0, 1, 0, 0);  chk("ovf_s2", a_ovf, 0);
      drv_a(0, 0, 1, 0, 0);  chk("ovf_s3", a_ovf, 1); chk("ovf_s3_cnt", a_cnt, 4);
      // read clock-enable low: no sends, flag stays sticky
      for (int k = 0; k < 10; k++) begin
         drv_a(0, 1, 0, 0, 32'hdead);
         chk($sformatf("ce_read_%0d", k), a_read, 0);
         chk($sformatf("ce_cnt_%0d", k), a_cnt, 4);
         chk($sformatf("ce_ovf_%0d", k), a_ovf, 1);
      end
      drv_a(0, 1, 1, 0, 32'h300); chk("res_r0_read", a_read, 1); chk("res_r0_cnt", a_cnt, 4);
      drv_a(0, 1, 1, 0, 32'h301); chk("res_r1_read", a_read, 1); chk("res_r1_cnt", a_cnt, 3);
      // reset with two words in flight
      drv_a(1, 1, 1, 0, 32'h302);
      chk("rst_r2_read", a_read, 0); chk("rst_r2_valid", a_valid, 1);
      chk("rst_r2_data", a_data, 32'h300); chk("rst_r2_cnt", a_cnt, 2);
      for (int k = 3; k < 8; k++) begin
         drv_a(0, 0, 1, 0, 0);
         chk($sformatf("rst_valid_%0d", k), a_valid, 0);
         chk($sformatf("rst_cnt_%0d", k), a_cnt, 4);
         chk($sformatf("rst_ovf_%0d", k), a_ovf, 0);
      end
      // loopback throughput: 100 words, one per cycle, in order
      for (int k = 0; k < 104; k++) begin
         @(posedge clk);
         #1;
         rb = 1'b0; b_empty_n = (k < 100); b_dout = 32'(k);
         #1;
         if (k < 100) chk($sformatf("loop_read_%0d", k), b_read, 1);
         if (k >= 2 && k < 102) begin
            chk($sformatf("loop_valid_%0d", k), b_valid, 1);
            chk($sformatf("loop_data_%0d", k), b_data, 32'(k - 2));
         end else chk($sformatf("loop_idle_%0d", k), b_valid, 0);
      end
      for (int k = 0; k < 4; k++) @(posedge clk);
      #2;
      chk("loop_cnt_end", b_cnt, 6);
      chk("loop_ovf_end", b_ovf, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
